// File: rtl/hazard_pkg.sv
// Shared types for the ID-stage hazard scheduler: FSM states, in-flight slot record,
// register-zero constant and the saturating stall-counter helper.
package hazard_pkg;

    localparam int REG_ADDR_W  = 5;
    localparam int STALL_CNT_W = 16;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

    typedef enum logic [1:0] {
        HZ_RUN   = 2'd0,
        HZ_STALL = 2'd1,
        HZ_FLUSH = 2'd2
    } hz_state_e;

    typedef struct packed {
        logic                  valid;
        logic                  reg_write;
        logic [REG_ADDR_W-1:0] dest;
        logic                  is_load;
    } inflight_t;

    localparam inflight_t SLOT_EMPTY = '0;

    function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] v);
        return (&v) ? v : v + STALL_CNT_W'(1);
    endfunction

endpackage

// File: rtl/hazard_inflight_pipe.sv
// Shift register of instructions in flight between ID and register-file write
// (slot 0 = EX ... slot PIPE_DEPTH-1 = WB), with per-slot source-register compares.
module hazard_inflight_pipe
    import hazard_pkg::*;
#(
    parameter int PIPE_DEPTH = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  hold_i,
    input  inflight_t             entry_i,
    input  logic [REG_ADDR_W-1:0] rs_i,
    input  logic [REG_ADDR_W-1:0] rt_i,
    output logic [PIPE_DEPTH-1:0] match_rs_o,
    output logic [PIPE_DEPTH-1:0] match_rt_o,
    output logic [PIPE_DEPTH-1:0] load_rs_o,
    output logic [PIPE_DEPTH-1:0] load_rt_o
);

    inflight_t [PIPE_DEPTH-1:0] slot_q;
    inflight_t [PIPE_DEPTH-1:0] slot_d;

    always_comb begin
        slot_d = slot_q;
        if (!hold_i) begin
            slot_d[0] = entry_i;
            for (int k = 1; k < PIPE_DEPTH; k++) begin
                slot_d[k] = slot_q[k-1];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int k = 0; k < PIPE_DEPTH; k++) begin
                slot_q[k] <= SLOT_EMPTY;
            end
        end else begin
            slot_q <= slot_d;
        end
    end

    // A slot only counts as a producer if it is real and actually writes back.
    always_comb begin
        for (int k = 0; k < PIPE_DEPTH; k++) begin
            match_rs_o[k] = slot_q[k].valid & slot_q[k].reg_write & (slot_q[k].dest == rs_i);
            match_rt_o[k] = slot_q[k].valid & slot_q[k].reg_write & (slot_q[k].dest == rt_i);
            load_rs_o[k]  = slot_q[k].valid & slot_q[k].reg_write & slot_q[k].is_load
                            & (slot_q[k].dest == rs_i);
            load_rt_o[k]  = slot_q[k].valid & slot_q[k].reg_write & slot_q[k].is_load
                            & (slot_q[k].dest == rt_i);
        end
    end

endmodule

// File: rtl/id_hazard_scheduler.sv
// ID-stage issue/stall/flush scheduler: watches in-flight writers and the EX redirect and
// drives PC / IF-ID enables, the ID/EX bubble and the IF/ID flush.
//   state    | meaning
//   HZ_RUN   | issuing normally
//   HZ_STALL | holding the ID instruction behind a data hazard
//   HZ_FLUSH | squashing wrong-path fetches after a redirect, flush_cnt_q cycles left
module id_hazard_scheduler
    import hazard_pkg::*;
#(
    parameter int PIPE_DEPTH     = 3,
    parameter int FWD_EN         = 1,
    parameter int BRANCH_PENALTY = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   id_valid,
    input  logic [REG_ADDR_W-1:0]  id_rs,
    input  logic [REG_ADDR_W-1:0]  id_rt,
    input  logic                   id_uses_rs,
    input  logic                   id_uses_rt,
    input  logic [REG_ADDR_W-1:0]  id_dest,
    input  logic                   id_reg_write,
    input  logic                   id_mem_read,
    input  logic                   redirect,
    input  logic                   ext_stall,
    output logic                   PCWrite,
    output logic                   if_id_write,
    output logic                   id_bubble,
    output logic                   flush_if_id,
    output logic [1:0]             hz_state,
    output logic [STALL_CNT_W-1:0] stall_count
);

    localparam int CNT_W = (BRANCH_PENALTY > 1) ? $clog2(BRANCH_PENALTY) : 1;
    localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(BRANCH_PENALTY - 1);
    // With forwarding only a load sitting in EX cannot be bypassed in time.
    localparam logic [PIPE_DEPTH-1:0] FWD_SLOTS = PIPE_DEPTH'(1);

    hz_state_e              state_q, state_d;
    logic [CNT_W-1:0]       flush_cnt_q, flush_cnt_d;
    logic                   redirect_pend_q, redirect_pend_d;
    logic [STALL_CNT_W-1:0] stall_count_q, stall_count_d;

    logic                   rs_live, rt_live, hazard, redirect_any, pipe_hold;
    inflight_t              issue_entry;
    logic [PIPE_DEPTH-1:0]  match_rs, match_rt, load_rs, load_rt;

    hazard_inflight_pipe #(
        .PIPE_DEPTH (PIPE_DEPTH)
    ) u_inflight (
        .clk_i      (clk),
        .rst_ni     (rst),
        .hold_i     (pipe_hold),
        .entry_i    (issue_entry),
        .rs_i       (id_rs),
        .rt_i       (id_rt),
        .match_rs_o (match_rs),
        .match_rt_o (match_rt),
        .load_rs_o  (load_rs),
        .load_rt_o  (load_rt)
    );

    assign rs_live      = id_valid & id_uses_rs & (id_rs != REG_ZERO);
    assign rt_live      = id_valid & id_uses_rt & (id_rt != REG_ZERO);
    assign redirect_any = redirect | redirect_pend_q;

    always_comb begin
        if (FWD_EN != 0) begin
            hazard = (rs_live & (|(load_rs & FWD_SLOTS)))
                   | (rt_live & (|(load_rt & FWD_SLOTS)));
        end else begin
            hazard = (rs_live & (|match_rs)) | (rt_live & (|match_rt));
        end
    end

    always_comb begin
        state_d         = state_q;
        flush_cnt_d     = flush_cnt_q;
        redirect_pend_d = redirect_pend_q;
        stall_count_d   = stall_count_q;
        PCWrite         = 1'b0;
        if_id_write     = 1'b0;
        id_bubble       = 1'b0;
        flush_if_id     = 1'b0;
        pipe_hold       = 1'b1;
        issue_entry     = SLOT_EMPTY;

        if (!rst) begin
            id_bubble = 1'b1;
        end else if (ext_stall) begin
            if (redirect) begin
                redirect_pend_d = 1'b1;
            end
        end else begin
            pipe_hold       = 1'b0;
            redirect_pend_d = 1'b0;
            if (redirect_any) begin
                PCWrite     = 1'b1;
                id_bubble   = 1'b1;
                flush_if_id = 1'b1;
                state_d     = HZ_FLUSH;
                flush_cnt_d = FLUSH_LOAD;
            end else begin
                case (state_q)
                    HZ_FLUSH: begin
                        PCWrite     = 1'b1;
                        id_bubble   = 1'b1;
                        flush_if_id = 1'b1;
                        if (flush_cnt_q == '0) begin
                            state_d = HZ_RUN;
                        end else begin
                            flush_cnt_d = flush_cnt_q - CNT_W'(1);
                        end
                    end
                    HZ_RUN, HZ_STALL: begin
                        if (hazard) begin
                            id_bubble     = 1'b1;
                            state_d       = HZ_STALL;
                            stall_count_d = sat_inc(stall_count_q);
                        end else begin
                            PCWrite               = 1'b1;
                            if_id_write           = 1'b1;
                            state_d               = HZ_RUN;
                            issue_entry.valid     = id_valid;
                            issue_entry.reg_write = id_reg_write;
                            issue_entry.dest      = id_dest;
                            issue_entry.is_load   = id_mem_read;
                        end
                    end
                    default: begin
                        id_bubble = 1'b1;
                        state_d   = HZ_RUN;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q         <= HZ_RUN;
            flush_cnt_q     <= '0;
            redirect_pend_q <= 1'b0;
            stall_count_q   <= '0;
        end else begin
            state_q         <= state_d;
            flush_cnt_q     <= flush_cnt_d;
            redirect_pend_q <= redirect_pend_d;
            stall_count_q   <= stall_count_d;
        end
    end

    assign hz_state    = state_q;
    assign stall_count = stall_count_q;

endmodule
